// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / load-store) onto a single shared memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to requester 1.
module mem_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              order0,
  input  logic              order1,
  input  logic              io0,
  input  logic              io1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        wstrb0,
  input  logic [3:0]        wstrb1,
  output logic              accepted0,
  output logic              accepted1,
  output logic              accessed0,
  output logic              accessed1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] a_mem,
  output logic [31:0]       sd_mem,
  input  logic [31:0]       ld_mem,
  output logic [3:0]        mem_write_flag,
  output logic              mem_read_flag
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic                r_grant;
  logic [2:0]          r_cnt;
  logic                r_pend0, r_pend1;
  logic                r_io0, r_io1;
  logic [ADDR_W-1:0]   r_addr0, r_addr1;
  logic [31:0]         r_wdata0, r_wdata1;
  logic [3:0]          r_wstrb0, r_wstrb1;

  logic                w_cap0, w_cap1, w_clr0, w_clr1;
  logic                w_arb, w_launch, w_ngrant, w_gio, w_complete;
  logic                w_nio;
  logic [ADDR_W-1:0]   w_naddr;
  logic [31:0]         w_nwdata;
  logic [3:0]          w_nwstrb;

  // The requester being completed in DONE may immediately queue its next order.
  assign w_clr0 = (r_state == S_DONE) && !r_grant;
  assign w_clr1 = (r_state == S_DONE) &&  r_grant;
  assign w_cap0 = order0 && (!r_pend0 || w_clr0);
  assign w_cap1 = order1 && (!r_pend1 || w_clr1);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;
  assign w_arb = (r_pend0 && r_pend1) ? r_ptr : r_pend1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= 1'b0;
    end else if (r_state == S_IDLE && w_launch) begin
      r_ptr <= ~w_arb;
    end
  end
`else
  assign w_arb = r_pend1;
`endif

  // DONE hands the port straight to the other requester if it is waiting.
  assign w_launch = ((r_state == S_IDLE) && (r_pend0 || r_pend1)) ||
                    ((r_state == S_DONE) && (r_grant ? r_pend0 : r_pend1));
  assign w_ngrant = (r_state == S_DONE) ? ~r_grant : w_arb;
  assign w_nio    = w_ngrant ? r_io1    : r_io0;
  assign w_naddr  = w_ngrant ? r_addr1  : r_addr0;
  assign w_nwdata = w_ngrant ? r_wdata1 : r_wdata0;
  assign w_nwstrb = w_ngrant ? r_wstrb1 : r_wstrb0;
  assign w_gio    = r_grant  ? r_io1    : r_io0;

  assign w_complete = ((r_state == S_ISSUE) && (w_gio || RD_LATENCY == 1)) ||
                      ((r_state == S_WAIT)  && (r_cnt == 3'(RD_LATENCY - 1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
    end else begin
      if (w_cap0)      r_pend0 <= 1'b1;
      else if (w_clr0) r_pend0 <= 1'b0;
      if (w_cap1)      r_pend1 <= 1'b1;
      else if (w_clr1) r_pend1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap0) begin
      r_io0    <= io0;
      r_addr0  <= addr0;
      r_wdata0 <= wdata0;
      r_wstrb0 <= wstrb0;
    end
    if (w_cap1) begin
      r_io1    <= io1;
      r_addr1  <= addr1;
      r_wdata1 <= wdata1;
      r_wstrb1 <= wstrb1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_grant        <= 1'b0;
      r_cnt          <= 3'd0;
      accepted0      <= 1'b0;
      accepted1      <= 1'b0;
      accessed0      <= 1'b0;
      accessed1      <= 1'b0;
      rdata0         <= 32'd0;
      rdata1         <= 32'd0;
      a_mem          <= '0;
      sd_mem         <= 32'd0;
      mem_write_flag <= 4'd0;
      mem_read_flag  <= 1'b0;
    end else begin
      accepted0      <= 1'b0;
      accepted1      <= 1'b0;
      accessed0      <= 1'b0;
      accessed1      <= 1'b0;
      mem_write_flag <= 4'd0;
      mem_read_flag  <= 1'b0;

      if (w_launch) begin
        r_state        <= S_ISSUE;
        r_grant        <= w_ngrant;
        accepted0      <= !w_ngrant;
        accepted1      <=  w_ngrant;
        a_mem          <= w_naddr;
        sd_mem         <= w_nwdata;
        mem_write_flag <= w_nio ? w_nwstrb : 4'd0;
        mem_read_flag  <= !w_nio;
      end else if (w_complete) begin
        r_state   <= S_DONE;
        accessed0 <= !r_grant;
        accessed1 <=  r_grant;
        if (!w_gio) begin
          if (r_grant) rdata1 <= ld_mem;
          else         rdata0 <= ld_mem;
        end
      end else if (r_state == S_ISSUE) begin
        r_state <= S_WAIT;
        r_cnt   <= 3'd1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 3'd1;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-enable memory model of read latency 2.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 17;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              order0, order1, io0, io1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic [3:0]        wstrb0, wstrb1;
  logic              accepted0, accepted1, accessed0, accessed1;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] a_mem;
  logic [31:0]       sd_mem, ld_mem;
  logic [3:0]        mem_write_flag;
  logic              mem_read_flag;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .order0(order0), .order1(order1), .io0(io0), .io1(io1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wstrb0(wstrb0), .wstrb1(wstrb1),
    .accepted0(accepted0), .accepted1(accepted1),
    .accessed0(accessed0), .accessed1(accessed1),
    .rdata0(rdata0), .rdata1(rdata1),
    .a_mem(a_mem), .sd_mem(sd_mem), .ld_mem(ld_mem),
    .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data for a read is presented one cycle after the strobe (latency 2).
  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;
  logic        r_rvld = 1'b0;
  logic [7:0]  r_raddr = 8'd0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (mem_write_flag[b]) mem[a_mem[7:0]][b*8 +: 8] <= sd_mem[b*8 +: 8];
    r_rvld  <= mem_read_flag;
    r_raddr <= a_mem[7:0];
  end
  assign ld_mem = r_rvld ? mem[r_raddr] : 32'hBAD0BAD0;

  int n_acc0 = 0, n_acc1 = 0, n_axs0 = 0, n_axs1 = 0, n_wr = 0, n_rd = 0;
  int t_acc0 = 0, t_acc1 = 0, t_axs0 = 0, t_axs1 = 0, t_wr = 0, t_rd = 0;
  logic [3:0]        wr_val = 4'd0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [31:0]       axs0_data = 32'd0, axs1_data = 32'd0;

  always @(negedge clk) begin
    if (accepted0) begin n_acc0 <= n_acc0 + 1; t_acc0 <= cyc; end
    if (accepted1) begin n_acc1 <= n_acc1 + 1; t_acc1 <= cyc; end
    if (accessed0) begin n_axs0 <= n_axs0 + 1; t_axs0 <= cyc; axs0_data <= rdata0; end
    if (accessed1) begin n_axs1 <= n_axs1 + 1; t_axs1 <= cyc; axs1_data <= rdata1; end
    if (|mem_write_flag) begin n_wr <= n_wr + 1; t_wr <= cyc; wr_val <= mem_write_flag; end
    if (mem_read_flag) begin n_rd <= n_rd + 1; t_rd <= cyc; rd_addr <= a_mem; end
  end

  int tests = 0;
  int fails = 0;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step(1);
    pl_we = 1'b0;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    int b0;
    rstn = 1'b1;
    step(1);
    rstn = 1'b0;
    order0 = 1'b1; addr0 = 17'h5;
    step(2);
    tests++;
    if ({accepted0, accepted1, accessed0, accessed1, mem_read_flag} !== 5'b0) begin
      fails++; $display("FAIL reset_pulses got %b exp 00000", {accepted0, accepted1, accessed0, accessed1, mem_read_flag});
    end
    tests++;
    if (rdata0 !== 32'd0) begin fails++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
    tests++;
    if (rdata1 !== 32'd0) begin fails++; $display("FAIL reset_rdata1 got %h exp 0", rdata1); end
    tests++;
    if (a_mem !== '0) begin fails++; $display("FAIL reset_a_mem got %h exp 0", a_mem); end
    tests++;
    if (sd_mem !== 32'd0) begin fails++; $display("FAIL reset_sd_mem got %h exp 0", sd_mem); end
    tests++;
    if (mem_write_flag !== 4'd0) begin fails++; $display("FAIL reset_wflag got %h exp 0", mem_write_flag); end
    b0 = n_acc0;
    order0 = 1'b0;
    rstn = 1'b1;
    step(6);
    tests++;
    if (n_acc0 - b0 !== 0) begin fails++; $display("FAIL reset_order_dropped got %0d accepts exp 0", n_acc0 - b0); end
  endtask

  task automatic test_read0;
    int n, ba, bx, br;
    ba = n_acc0; bx = n_axs0; br = n_rd;
    order0 = 1'b1; io0 = 1'b0; addr0 = 17'h10; n = cyc;
    step(1);
    order0 = 1'b0;
    step(8);
    tests++;
    if (n_acc0 - ba !== 1 || t_acc0 !== n + 2) begin
      fails++; $display("FAIL read0_accept got cnt %0d at %0d exp cnt 1 at %0d", n_acc0 - ba, t_acc0, n + 2);
    end
    tests++;
    if (n_rd - br !== 1 || t_rd !== n + 2 || rd_addr !== 17'h10) begin
      fails++; $display("FAIL read0_strobe got cnt %0d at %0d addr %h exp 1 at %0d addr 10", n_rd - br, t_rd, rd_addr, n + 2);
    end
    tests++;
    if (n_axs0 - bx !== 1 || t_axs0 !== n + 4) begin
      fails++; $display("FAIL read0_accessed got cnt %0d at %0d exp cnt 1 at %0d", n_axs0 - bx, t_axs0, n + 4);
    end
    tests++;
    if (axs0_data !== 32'hDEADBEEF || rdata0 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL read0_data got %h/%h exp deadbeef", axs0_data, rdata0);
    end
  endtask

  task automatic test_write1;
    int n, bw, br;
    bw = n_wr; br = n_rd;
    order1 = 1'b1; io1 = 1'b1; addr1 = 17'h20; wdata1 = 32'h12345678; wstrb1 = 4'h3; n = cyc;
    step(1);
    order1 = 1'b0;
    step(8);
    tests++;
    if (n_wr - bw !== 1 || wr_val !== 4'h3 || t_wr !== n + 2) begin
      fails++; $display("FAIL write1_wflag got cnt %0d val %h at %0d exp 1 val 3 at %0d", n_wr - bw, wr_val, t_wr, n + 2);
    end
    tests++;
    if (n_rd - br !== 0) begin fails++; $display("FAIL write1_no_read got %0d exp 0", n_rd - br); end
    tests++;
    if (t_acc1 !== n + 2 || t_axs1 !== n + 3) begin
      fails++; $display("FAIL write1_timing got acc %0d axs %0d exp %0d %0d", t_acc1, t_axs1, n + 2, n + 3);
    end
    order1 = 1'b1; io1 = 1'b0; addr1 = 17'h20; n = cyc;
    step(1);
    order1 = 1'b0;
    step(8);
    tests++;
    if (rdata1 !== 32'hAAAA5678 || t_axs1 !== n + 4) begin
      fails++; $display("FAIL write1_readback got %h at %0d exp aaaa5678 at %0d", rdata1, t_axs1, n + 4);
    end
  endtask

  task automatic test_contention;
    int n, e_acc0, e_acc1, e_axs0, e_axs1;
    logic first0;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      if (round == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        first0 = 1'b1;
`else
        first0 = 1'b0;
`endif
      end else begin
        first0 = 1'b0;
      end
      order0 = 1'b1; io0 = 1'b0; addr0 = 17'h10;
      order1 = 1'b1; io1 = 1'b0; addr1 = 17'h20;
      n = cyc;
      step(1);
      order0 = 1'b0; order1 = 1'b0;
      step(10);
      e_acc0 = first0 ? n + 2 : n + 5;
      e_axs0 = first0 ? n + 4 : n + 7;
      e_acc1 = first0 ? n + 5 : n + 2;
      e_axs1 = first0 ? n + 7 : n + 4;
      tests++;
      if (t_acc0 !== e_acc0 || t_acc1 !== e_acc1) begin
        fails++; $display("FAIL contend%0d_accept got %0d/%0d exp %0d/%0d", round, t_acc0, t_acc1, e_acc0, e_acc1);
      end
      tests++;
      if (t_axs0 !== e_axs0 || t_axs1 !== e_axs1) begin
        fails++; $display("FAIL contend%0d_accessed got %0d/%0d exp %0d/%0d", round, t_axs0, t_axs1, e_axs0, e_axs1);
      end
      tests++;
      if (rdata0 !== 32'hDEADBEEF || rdata1 !== 32'hAAAA5678) begin
        fails++; $display("FAIL contend%0d_data got %h/%h exp deadbeef/aaaa5678", round, rdata0, rdata1);
      end
    end
  endtask

  task automatic test_ignore_pending;
    int ba, bx;
    ba = n_acc0; bx = n_axs0;
    order0 = 1'b1; io0 = 1'b0; addr0 = 17'h10;
    step(1);
    addr0 = 17'h30;
    step(1);
    order0 = 1'b0;
    step(1);
    order0 = 1'b1;
    step(1);
    order0 = 1'b0;
    step(8);
    tests++;
    if (n_acc0 - ba !== 1 || n_axs0 - bx !== 1) begin
      fails++; $display("FAIL ignore_counts got acc %0d axs %0d exp 1 1", n_acc0 - ba, n_axs0 - bx);
    end
    tests++;
    if (rd_addr !== 17'h10) begin fails++; $display("FAIL ignore_addr got %h exp 10", rd_addr); end
  endtask

  task automatic test_done_relatch;
    int n, ba;
    ba = n_acc0;
    order0 = 1'b1; io0 = 1'b0; addr0 = 17'h10; n = cyc;
    step(1);
    order0 = 1'b0;
    step(3);
    order0 = 1'b1; addr0 = 17'h20;
    step(1);
    order0 = 1'b0;
    step(8);
    tests++;
    if (n_acc0 - ba !== 2 || t_acc0 !== n + 6 || t_axs0 !== n + 8) begin
      fails++; $display("FAIL relatch_timing got cnt %0d acc %0d axs %0d exp 2 %0d %0d", n_acc0 - ba, t_acc0, t_axs0, n + 6, n + 8);
    end
    tests++;
    if (rdata0 !== 32'hAAAA5678) begin fails++; $display("FAIL relatch_data got %h exp aaaa5678", rdata0); end
  endtask

  task automatic test_reset_mid;
    int n, bx;
    order0 = 1'b1; io0 = 1'b0; addr0 = 17'h20;
    step(1);
    order0 = 1'b0;
    step(2);
    bx = n_axs0;
    rstn = 1'b0;
    #1;
    tests++;
    if (rdata0 !== 32'd0 || a_mem !== '0 || sd_mem !== 32'd0 ||
        {accepted0, accessed0, mem_read_flag, mem_write_flag} !== 7'd0) begin
      fails++; $display("FAIL midreset_outputs got rdata0 %h a_mem %h sd %h flags %b exp all 0",
                        rdata0, a_mem, sd_mem, {accepted0, accessed0, mem_read_flag, mem_write_flag});
    end
    step(2);
    rstn = 1'b1;
    step(6);
    tests++;
    if (n_axs0 - bx !== 0) begin fails++; $display("FAIL midreset_no_access got %0d exp 0", n_axs0 - bx); end
    order0 = 1'b1; io0 = 1'b0; addr0 = 17'h10; n = cyc;
    step(1);
    order0 = 1'b0;
    step(8);
    tests++;
    if (t_axs0 !== n + 4 || rdata0 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL midreset_recover got %h at %0d exp deadbeef at %0d", rdata0, t_axs0, n + 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    order0 = 1'b0; order1 = 1'b0; io0 = 1'b0; io1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = 32'd0; wdata1 = 32'd0; wstrb0 = 4'd0; wstrb1 = 4'd0;
    step(2);
    test_reset();
    mem_load(8'h10, 32'hDEADBEEF);
    mem_load(8'h20, 32'hAAAAAAAA);
    step(1);
    test_read0();
    test_write1();
    test_contention();
    test_ignore_pending();
    test_done_relatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
